rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Arbitrates the single register-file write port between several write-back requesters: memory load, ALU result and debug/host write. Uses round-robin arbitration with valid/ready handshakes. The winning request is registered and presented to the register file's write port one cycle later. A lock input reserves the port for the debug requester during host access.

Parameters:
NUM_REQ, 3, number of requesters; index NUM_REQ-1 is the debug requester
DATA_W, 16, write data width
REG_AW, 3, register address width (2**REG_AW registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
i_req_valid  in  NUM_REQ  per-requester write request valid
i_req_reg  in  NUM_REQ*REG_AW  per-requester destination register, requester i at bits [i*REG_AW +: REG_AW]
i_req_data  in  NUM_REQ*DATA_W  per-requester write data, requester i at bits [i*DATA_W +: DATA_W]
o_req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high at a rising edge
i_lock  in  1  when 1, only requester NUM_REQ-1 is eligible
o_RF_write  out  1  register-file write enable
o_reg_w  out  REG_AW  register-file write address
o_data_w  out  DATA_W  register-file write data
o_busy  out  1  1 when any i_req_valid bit is high and is not granted this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - o_RF_write=0, o_reg_w=0, o_data_w=0.
  - Round-robin pointer ptr=0.
  - Any accepted-but-uncommitted write is discarded.
  - o_req_ready is 0 while in reset.
- Eligibility: eligible[i] = i_req_valid[i] and (not i_lock or i == NUM_REQ-1).
- Grant (combinational, same cycle):
  - Grant the first eligible index scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - At most one bit of o_req_ready is high.
  - o_req_ready is 0 when no requester is eligible.
  - o_req_ready may depend on i_req_valid; requesters must not make valid depend on ready.
- Pointer update at rising edge:
  - If a grant occurs, ptr <= (granted index + 1) mod NUM_REQ.
  - Otherwise ptr holds.
  - A locked debug grant updates ptr the same way.
- Commit stage, registered, latency 1:
  - At the edge where requester g is granted: o_RF_write<=1, o_reg_w<=i_req_reg[g], o_data_w<=i_req_data[g].
  - At an edge with no grant: o_RF_write<=0; o_reg_w and o_data_w hold their previous values.
  - Back-to-back grants produce o_RF_write high on consecutive cycles; throughput is 1 write per cycle.
- Same destination register from multiple requesters: no merging. Each grant produces its own commit, in grant order.
- i_lock asserted while a non-debug requester holds valid: that requester is stalled (ready=0) and keeps its request. The commit already in the output stage still completes.
- i_lock=1 with debug not valid: no grant and o_RF_write=0 on the next cycle.
- Requester dropping valid without a handshake is legal. It is simply not granted; no state is retained per requester.
- Register 0 is an ordinary writable destination; no special casing.
- o_busy = |eligible_or_blocked_valid & ~o_req_ready. It is 1 when any valid request (including lock-blocked ones) is not granted this cycle.

Test Plan:
- Reset, then single request:
  - Stimulus: assert rst=0 then release; drive req1 valid, reg=3'd5, data=16'hBEEF for one cycle.
  - Response: ready=3'b010 that cycle; next cycle o_RF_write=1, o_reg_w=5, o_data_w=16'hBEEF; the following cycle o_RF_write=0.
- Round-robin fairness:
  - Stimulus: all three valid continuously from ptr=0 for 6 cycles.
  - Response: grants in order 0,1,2,0,1,2; o_RF_write high for 6 consecutive cycles with matching reg/data.
- Pointer skip:
  - Stimulus: ptr=1 with only req0 and req2 valid.
  - Response: req2 granted first, ptr becomes 0, then req0 granted.
- Lock:
  - Stimulus: i_lock=1 with req0 and req2 valid (req2 reg=3'd7, data=16'h1234).
  - Response: only req2 granted; commit reg 7 / 16'h1234; req0 ready=0 and o_busy=1 until lock drops, then req0 granted.
- Lock with no debug request:
  - Stimulus: i_lock=1, only req1 valid.
  - Response: no grant, o_RF_write=0, o_busy=1.
- Reset mid-operation:
  - Stimulus: grant req0 (data=16'h00FF), then assert rst=0 asynchronously before the next rising edge.
  - Response: o_RF_write=0 immediately; no commit after release; ptr=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the requesters and the register-file write arbiter.
// The arbiter sits on the slave side and the requesters/register file on the master side.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3
);
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*REG_AW-1:0] i_req_reg;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic                      i_lock;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_RF_write;
  logic [REG_AW-1:0]         o_reg_w;
  logic [DATA_W-1:0]         o_data_w;
  logic                      o_busy;

  modport master (
    output i_req_valid, i_req_reg, i_req_data, i_lock,
    input  o_req_ready, o_RF_write, o_reg_w, o_data_w, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_reg, i_req_data, i_lock,
    output o_req_ready, o_RF_write, o_reg_w, o_data_w, o_busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a debug lock.
// The granted write is registered and presented to the register file one cycle later.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] DBG_ONLY = NUM_REQ'(1) << (NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               rf_write_q, rf_write_d;
  logic [REG_AW-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   idx;

  // While locked, only the debug requester (highest index) may win.
  assign eligible = bus.i_req_valid & (bus.i_lock ? DBG_ONLY : '1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      idx = cand[PTR_W-1:0];
      // Ready is held low during reset even though the scan itself is combinational.
      if (rst && !gnt_any && eligible[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_write_d = gnt_any;
    reg_d      = reg_q;
    data_d     = data_q;
    if (gnt_any) begin
      ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      reg_d  = bus.i_req_reg[gnt_idx*REG_AW +: REG_AW];
      data_d = bus.i_req_data[gnt_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      rf_write_q <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values together.
      ptr_q      <= ptr_d;
      rf_write_q <= rf_write_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
    end
  end

  assign bus.o_req_ready = gnt_oh;
  assign bus.o_RF_write  = rf_write_q;
  assign bus.o_reg_w     = reg_q;
  assign bus.o_data_w    = data_q;
  // Lock-blocked requests are still valid, so they count as waiting.
  assign bus.o_busy      = |(bus.i_req_valid & ~gnt_oh);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected commits, a monitor pops
// and compares them whenever the register-file write enable is seen.
module tb_rf_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;

  typedef struct packed {
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] dat;
  } commit_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  commit_t           sb[$];
  logic [REG_AW-1:0] rr [NUM_REQ];
  logic [DATA_W-1:0] rd [NUM_REQ];

  rf_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of requests at the falling edge and check the combinational grant.
  task automatic step(input logic [2:0] v, input logic lk, input logic [2:0] exp_rdy,
                      input logic exp_busy, input string tag);
    @(negedge clk);
    bus.i_req_valid = v;
    bus.i_lock      = lk;
    bus.i_req_reg   = {rr[2], rr[1], rr[0]};
    bus.i_req_data  = {rd[2], rd[1], rd[0]};
    #1;
    check({tag, "_ready"}, 32'(bus.o_req_ready), 32'(exp_rdy));
    check({tag, "_busy"},  32'(bus.o_busy),      32'(exp_busy));
    for (int g = 0; g < NUM_REQ; g++)
      if (exp_rdy[g]) sb.push_back('{rg: rr[g], dat: rd[g]});
  endtask

  // Monitor: every observed write must match the oldest expected commit.
  initial begin
    commit_t c;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.o_RF_write === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: write reg %0d data 0x%0h, none expected at %0t",
                   bus.o_reg_w, bus.o_data_w, $time);
        end else begin
          c = sb.pop_front();
          check("sb_reg",  32'(bus.o_reg_w),  32'(c.rg));
          check("sb_data", 32'(bus.o_data_w), 32'(c.dat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rr[i] = '0;
      rd[i] = '0;
    end
    bus.i_req_valid = '0;
    bus.i_req_reg   = '0;
    bus.i_req_data  = '0;
    bus.i_lock      = 1'b0;
    rst = 1'b0;

    // Reset: outputs cleared and no grant even with every requester valid.
    @(negedge clk);
    bus.i_req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(bus.o_req_ready), 32'h0);
    check("rst_write", 32'(bus.o_RF_write),  32'h0);
    check("rst_reg",   32'(bus.o_reg_w),     32'h0);
    check("rst_data",  32'(bus.o_data_w),    32'h0);
    @(negedge clk);
    bus.i_req_valid = '0;
    rst = 1'b1;

    // Single request from req1; ptr goes 0 -> 2.
    rr[1] = 3'd5; rd[1] = 16'hBEEF;
    step(3'b010, 1'b0, 3'b010, 1'b0, "single");
    step(3'b000, 1'b0, 3'b000, 1'b0, "idle0");

    // Lone debug request brings ptr back to 0.
    rr[2] = 3'd1; rd[2] = 16'h2222;
    step(3'b100, 1'b0, 3'b100, 1'b0, "ptr_wrap");

    // Round robin with all three valid: 0,1,2,0,1,2 (req0 writes register 0 first).
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rr[i] = 3'((i + k) % 8);
        rd[i] = 16'(16'h1000 * (i + 1) + k);
      end
      step(3'b111, 1'b0, 3'b001 << (k % 3), 1'b1, "rr");
    end

    // Same destination from two requesters: two separate commits in grant order.
    rr[0] = 3'd2; rd[0] = 16'h0A0A;
    step(3'b001, 1'b0, 3'b001, 1'b0, "set_ptr1");
    rr[0] = 3'd6; rd[0] = 16'h0B0B;
    rr[2] = 3'd6; rd[2] = 16'h0C0C;
    step(3'b101, 1'b0, 3'b100, 1'b1, "skip_first");
    step(3'b101, 1'b0, 3'b001, 1'b1, "skip_second");

    // Lock: only debug eligible; req0 stalls until the lock drops.
    rr[2] = 3'd7; rd[2] = 16'h1234;
    rr[0] = 3'd3; rd[0] = 16'h5555;
    step(3'b101, 1'b1, 3'b100, 1'b1, "lock_dbg");
    step(3'b001, 1'b1, 3'b000, 1'b1, "lock_stall");
    step(3'b001, 1'b0, 3'b001, 1'b0, "lock_release");

    // Lock with no debug request: nothing granted, nothing written.
    rr[1] = 3'd4; rd[1] = 16'h4444;
    step(3'b010, 1'b1, 3'b000, 1'b1, "lock_nodbg");
    step(3'b000, 1'b0, 3'b000, 1'b0, "idle1");
    @(negedge clk);
    check("lock_nodbg_write", 32'(bus.o_RF_write), 32'h0);

    // Reset mid-operation: a commit in the output stage is discarded at once.
    @(negedge clk);
    rr[0] = 3'd4; rd[0] = 16'h00FF;
    bus.i_req_valid = 3'b001;
    bus.i_lock      = 1'b0;
    bus.i_req_reg   = {rr[2], rr[1], rr[0]};
    bus.i_req_data  = {rd[2], rd[1], rd[0]};
    #1;
    check("midrst_ready", 32'(bus.o_req_ready), 32'h1);
    @(posedge clk);
    #1;
    check("midrst_commit_write", 32'(bus.o_RF_write), 32'h1);
    check("midrst_commit_data",  32'(bus.o_data_w),   32'h00FF);
    rst = 1'b0;
    #1;
    check("midrst_write", 32'(bus.o_RF_write), 32'h0);
    check("midrst_data",  32'(bus.o_data_w),   32'h0);
    check("midrst_ready_low", 32'(bus.o_req_ready), 32'h0);
    @(negedge clk);
    bus.i_req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // ptr back at 0: req0 wins over req1 (req1 would win if ptr had stayed at 1).
    rr[0] = 3'd1; rd[0] = 16'hA5A5;
    rr[1] = 3'd2; rd[1] = 16'h5A5A;
    step(3'b011, 1'b0, 3'b001, 1'b1, "post_rst");
    step(3'b000, 1'b0, 3'b000, 1'b0, "idle2");

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
